// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage Selen core.
// Produces per-stage enables/kills, execute bypass selects and stall bookkeeping.
module core_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_val,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_cop,
    input  logic [4:0]       exe_rd,
    input  logic [4:0]       mem_rd,
    input  logic             exe_we,
    input  logic             mem_we,
    input  logic             exe_load,
    input  logic             exe_brnch_tknn,
    input  logic             mem_l1d_val,
    input  logic             l1d_ack,
    output logic             if_enb,
    output logic             dec_enb,
    output logic             exe_enb,
    output logic             mem_enb,
    output logic             if_kill,
    output logic             dec_kill,
    output logic             exe_kill,
    output logic             mem_kill,
    output logic [3:0]       exe_bp,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              exe_v_q, exe_v_d;
    logic              mem_v_q, mem_v_d;
    logic [3:0]        bp_q, bp_d;

    logic [1:0][4:0]   src_rs;
    logic [1:0]        src_use;
    logic [1:0]        exe_match;
    logic [1:0]        m_hit;
    logic [1:0]        w_hit;
    logic [3:0]        bp_calc;

    logic              cond_memwait;
    logic              cond_flush;
    logic              cond_lduse;
    logic              cond_drain;
    logic              stalled;

    assign src_rs  = {dec_rs2, dec_rs1};
    assign src_use = {dec_use_rs2, dec_use_rs1};

    // Per-source compare; the memory-stage hit is masked by the execute hit so M wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign exe_match[gi] = src_use[gi] & (src_rs[gi] == exe_rd);
            assign m_hit[gi]     = exe_match[gi] & exe_we & (exe_rd != 5'd0);
            assign w_hit[gi]     = src_use[gi] & mem_we & (mem_rd != 5'd0)
                                 & (src_rs[gi] == mem_rd) & ~m_hit[gi];
        end
    endgenerate

    assign bp_calc = {~w_hit[1], ~m_hit[1], ~w_hit[0], ~m_hit[0]};

    assign cond_memwait = mem_l1d_val & mem_v_q & ~l1d_ack;
    assign cond_flush   = exe_brnch_tknn & exe_v_q;
    assign cond_lduse   = exe_load & exe_v_q & exe_we & (exe_rd != 5'd0)
                        & dec_val & (|exe_match);
    assign cond_drain   = dec_val & dec_cop & (exe_v_q | mem_v_q);

    always_comb begin
        state_d  = ST_RUN;
        if_enb   = 1'b1;
        dec_enb  = 1'b1;
        exe_enb  = 1'b1;
        mem_enb  = 1'b1;
        if_kill  = 1'b0;
        dec_kill = 1'b0;
        exe_kill = 1'b0;
        mem_kill = 1'b0;
        if (cond_memwait) begin
            state_d  = ST_MEMWAIT;
            if_enb   = 1'b0;
            dec_enb  = 1'b0;
            exe_enb  = 1'b0;
            mem_enb  = 1'b0;
            mem_kill = 1'b1;
        end else if (cond_flush) begin
            // Flush is not a stall: the pipe keeps moving, only the two younger slots die.
            state_d  = ST_RUN;
            if_kill  = 1'b1;
            dec_kill = 1'b1;
        end else if (cond_lduse) begin
            state_d  = ST_LDUSE;
            if_enb   = 1'b0;
            dec_kill = 1'b1;
        end else if (cond_drain) begin
            state_d  = ST_DRAIN;
            if_enb   = 1'b0;
            dec_kill = 1'b1;
        end
    end

    assign stalled = (state_d != ST_RUN);

    always_comb begin
        cnt_d = cnt_q;
        if (stalled && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        exe_v_d = exe_v_q;
        bp_d    = bp_q;
        if (dec_kill) begin
            exe_v_d = 1'b0;
            bp_d    = 4'hF;
        end else if (dec_enb) begin
            exe_v_d = dec_val;
            bp_d    = bp_calc;
        end
    end

    always_comb begin
        mem_v_d = mem_v_q;
        if (exe_kill) begin
            mem_v_d = 1'b0;
        end else if (exe_enb) begin
            mem_v_d = exe_v_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            exe_v_q <= 1'b0;
            mem_v_q <= 1'b0;
            bp_q    <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exe_v_q <= exe_v_d;
            mem_v_q <= mem_v_d;
            bp_q    <= bp_d;
        end
    end

    assign exe_bp    = bp_q;
    assign stall_cnt = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Scoreboard bench for core_pipe_ctrl: directed cycles push expectations,
// a negedge monitor pops and compares them.
module tb_core_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_val, dec_use_rs1, dec_use_rs2, dec_cop;
    logic [4:0]  dec_rs1, dec_rs2, exe_rd, mem_rd;
    logic        exe_we, mem_we, exe_load, exe_brnch_tknn, mem_l1d_val, l1d_ack;

    logic        if_enb, dec_enb, exe_enb, mem_enb;
    logic        if_kill, dec_kill, exe_kill, mem_kill;
    logic [3:0]  exe_bp;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    logic        s_if_enb, s_dec_enb, s_exe_enb, s_mem_enb;
    logic        s_if_kill, s_dec_kill, s_exe_kill, s_mem_kill;
    logic [3:0]  s_exe_bp;
    logic [1:0]  s_stall_cnt;
    logic [1:0]  s_state;

    always #5 clk = ~clk;

    core_pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .dec_val(dec_val), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_cop(dec_cop),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .exe_we(exe_we), .mem_we(mem_we),
        .exe_load(exe_load), .exe_brnch_tknn(exe_brnch_tknn),
        .mem_l1d_val(mem_l1d_val), .l1d_ack(l1d_ack),
        .if_enb(if_enb), .dec_enb(dec_enb), .exe_enb(exe_enb), .mem_enb(mem_enb),
        .if_kill(if_kill), .dec_kill(dec_kill), .exe_kill(exe_kill), .mem_kill(mem_kill),
        .exe_bp(exe_bp), .stall_cnt(stall_cnt), .state(state)
    );

    core_pipe_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .dec_val(dec_val), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_cop(dec_cop),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .exe_we(exe_we), .mem_we(mem_we),
        .exe_load(exe_load), .exe_brnch_tknn(exe_brnch_tknn),
        .mem_l1d_val(mem_l1d_val), .l1d_ack(l1d_ack),
        .if_enb(s_if_enb), .dec_enb(s_dec_enb), .exe_enb(s_exe_enb), .mem_enb(s_mem_enb),
        .if_kill(s_if_kill), .dec_kill(s_dec_kill), .exe_kill(s_exe_kill), .mem_kill(s_mem_kill),
        .exe_bp(s_exe_bp), .stall_cnt(s_stall_cnt), .state(s_state)
    );

    typedef enum {S_CTRL, S_BP, S_ST, S_CNT, S_SAT, S_EXEV} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [15:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // CTRL packing: {if_enb,dec_enb,exe_enb,mem_enb,if_kill,dec_kill,exe_kill,mem_kill}
    localparam logic [15:0] C_RUN   = 16'h00F0;
    localparam logic [15:0] C_STALL = 16'h0074;
    localparam logic [15:0] C_FLUSH = 16'h00FC;
    localparam logic [15:0] C_WAIT  = 16'h0001;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                S_CTRL: act = {8'h00, if_enb, dec_enb, exe_enb, mem_enb,
                               if_kill, dec_kill, exe_kill, mem_kill};
                S_BP:   act = {12'h000, exe_bp};
                S_ST:   act = {14'h0000, state};
                S_CNT:  act = stall_cnt;
                S_SAT:  act = {14'h0000, s_stall_cnt};
                default: act = {15'h0000, dut.exe_v_q};
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end else begin
                $display("[TB] ok %s = %h", e.name, act);
            end
        end
    end

    task automatic expect_v(input string name, input sel_e sel, input logic [15:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        dec_val = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        dec_cop = 0; exe_rd = 0; mem_rd = 0; exe_we = 0; mem_we = 0;
        exe_load = 0; exe_brnch_tknn = 0; mem_l1d_val = 0; l1d_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        expect_v("rst_ctrl", S_CTRL, C_RUN);
        expect_v("rst_bp",   S_BP,   16'hF);
        expect_v("rst_st",   S_ST,   16'd0);
        expect_v("rst_cnt",  S_CNT,  16'd0);
        expect_v("rst_exev", S_EXEV, 16'd0);
        step();
        rst = 1'b0;

        // Forwarding: both M and W match rs1, M wins
        idle(); dec_val = 1; dec_rs1 = 5; dec_use_rs1 = 1;
        exe_rd = 5; exe_we = 1; mem_rd = 5; mem_we = 1;
        expect_v("fwd_ctrl", S_CTRL, C_RUN);
        step();
        expect_v("fwd_m_bp", S_BP,   16'b1110);
        expect_v("fwd_exev", S_EXEV, 16'd1);
        exe_we = 0;
        step();
        expect_v("fwd_w_bp", S_BP, 16'b1101);
        idle(); dec_val = 1; dec_rs1 = 7; dec_use_rs1 = 1; dec_rs2 = 5; dec_use_rs2 = 1;
        exe_rd = 9; exe_we = 1; mem_rd = 5; mem_we = 1;
        step();
        expect_v("fwd_rs2w_bp", S_BP, 16'b0111);
        idle(); dec_val = 1; dec_rs1 = 0; dec_use_rs1 = 1;
        exe_rd = 0; exe_we = 1; mem_rd = 0; mem_we = 1;
        step();
        expect_v("fwd_rd0_bp", S_BP,  16'hF);
        expect_v("pre_ld_cnt", S_CNT, 16'd0);

        // Load-use: load rd=3 in execute, decode reads rs2=3
        idle(); dec_val = 1;
        step();
        idle(); dec_val = 1; dec_rs2 = 3; dec_use_rs2 = 1;
        exe_load = 1; exe_we = 1; exe_rd = 3;
        expect_v("ld_ctrl", S_CTRL, C_STALL);
        expect_v("ld_st0",  S_ST,   16'd0);
        step();
        expect_v("ld_st1",   S_ST,   16'd1);
        expect_v("ld_cnt",   S_CNT,  16'd1);
        expect_v("ld_sat",   S_SAT,  16'd1);
        expect_v("ld_bubv",  S_EXEV, 16'd0);
        expect_v("ld_bubbp", S_BP,   16'hF);
        idle(); dec_val = 1; dec_rs2 = 3; dec_use_rs2 = 1; mem_rd = 3; mem_we = 1;
        expect_v("ld_run_ctrl", S_CTRL, C_RUN);
        step();
        expect_v("ld_back_st", S_ST,   16'd0);
        expect_v("ld_back_cnt", S_CNT, 16'd1);
        expect_v("ld_w_bp",    S_BP,   16'b0111);
        expect_v("ld_exev",    S_EXEV, 16'd1);

        // Branch flush overriding a load-use condition
        idle(); dec_val = 1; dec_rs1 = 4; dec_use_rs1 = 1;
        exe_load = 1; exe_we = 1; exe_rd = 4; exe_brnch_tknn = 1;
        expect_v("br_ctrl", S_CTRL, C_FLUSH);
        step();
        expect_v("br_exev", S_EXEV, 16'd0);
        expect_v("br_st",   S_ST,   16'd0);
        expect_v("br_cnt",  S_CNT,  16'd1);
        expect_v("br_bp",   S_BP,   16'hF);
        idle(); dec_val = 1; exe_brnch_tknn = 1;
        expect_v("br_stale_ctrl", S_CTRL, C_RUN);
        step();
        idle(); dec_val = 1;
        step();

        // L1D wait with a taken branch pending; 4 wait cycles then ack
        for (int i = 0; i < 4; i++) begin
            idle(); dec_val = 1; mem_l1d_val = 1; exe_brnch_tknn = 1;
            expect_v($sformatf("wait%0d_ctrl", i), S_CTRL, C_WAIT);
            if (i > 0) begin
                expect_v($sformatf("wait%0d_st", i),  S_ST,  16'd2);
                expect_v($sformatf("wait%0d_cnt", i), S_CNT, 16'(1 + i));
            end
            step();
        end
        idle(); dec_val = 1; mem_l1d_val = 1; l1d_ack = 1; exe_brnch_tknn = 1;
        expect_v("ack_ctrl", S_CTRL, C_FLUSH);
        expect_v("ack_st",   S_ST,   16'd2);
        expect_v("ack_cnt",  S_CNT,  16'd5);
        expect_v("ack_sat",  S_SAT,  16'd3);
        step();
        expect_v("post_ack_st",   S_ST,   16'd0);
        expect_v("post_ack_exev", S_EXEV, 16'd0);
        idle(); dec_val = 1;
        step();
        idle(); dec_val = 1;
        step();

        // Drain before a cache-maintenance op with both stages full
        idle(); dec_val = 1; dec_cop = 1;
        expect_v("drn0_ctrl", S_CTRL, C_STALL);
        step();
        idle(); dec_val = 1; dec_cop = 1;
        expect_v("drn1_ctrl", S_CTRL, C_STALL);
        expect_v("drn1_st",   S_ST,   16'd3);
        expect_v("drn1_cnt",  S_CNT,  16'd6);
        step();
        idle(); dec_val = 1; dec_cop = 1;
        expect_v("drn2_ctrl", S_CTRL, C_RUN);
        expect_v("drn2_st",   S_ST,   16'd3);
        expect_v("drn2_sat",  S_SAT,  16'd3);
        step();
        idle(); dec_val = 1;
        expect_v("drn3_st",  S_ST,  16'd0);
        expect_v("drn3_cnt", S_CNT, 16'd7);
        step();

        // Reset asserted in the middle of a memory wait
        idle(); mem_l1d_val = 1;
        expect_v("rw0_ctrl", S_CTRL, C_WAIT);
        step();
        idle(); mem_l1d_val = 1;
        expect_v("rw1_ctrl", S_CTRL, C_WAIT);
        expect_v("rw1_st",   S_ST,   16'd2);
        expect_v("rw1_cnt",  S_CNT,  16'd8);
        #6;
        rst = 1'b1;
        #1;
        expect_v("rmid_ctrl", S_CTRL, C_RUN);
        expect_v("rmid_st",   S_ST,   16'd0);
        expect_v("rmid_cnt",  S_CNT,  16'd0);
        expect_v("rmid_sat",  S_SAT,  16'd0);
        expect_v("rmid_bp",   S_BP,   16'hF);
        expect_v("rmid_exev", S_EXEV, 16'd0);
        step();
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
